// File: rtl/mem_arbiter_if.sv
// Bundle between the two cache controllers, the arbiter and main memory.
// slave is the arbiter's view; master is the cores/memory side.
interface mem_arbiter_if;
    logic        req1;
    logic        req2;
    logic        we1;
    logic        we2;
    logic [11:0] addr1;
    logic [11:0] addr2;
    logic [31:0] wdata1;
    logic [31:0] wdata2;
    logic        ack1;
    logic        ack2;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
    logic [11:0] mem_addr;
    logic [31:0] mem_data;
    logic        mem_rden;
    logic        mem_wren;
    logic [31:0] mem_q;
    logic        busy;
    logic        inv1_valid;
    logic        inv2_valid;
    logic [11:0] inv_addr;

    modport slave (
        input  req1, req2, we1, we2, addr1, addr2, wdata1, wdata2, mem_q,
        output ack1, ack2, rdata1, rdata2, mem_addr, mem_data,
        output mem_rden, mem_wren, busy, inv1_valid, inv2_valid, inv_addr
    );

    modport master (
        output req1, req2, we1, we2, addr1, addr2, wdata1, wdata2, mem_q,
        input  ack1, ack2, rdata1, rdata2, mem_addr, mem_data,
        input  mem_rden, mem_wren, busy, inv1_valid, inv2_valid, inv_addr
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin two-core arbiter for the single-ported main memory.
// Define MEM_ARB_SNOOP_EN to broadcast write-invalidate pulses.
module mem_arbiter #(
    parameter int MEM_LAT = 1
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t      state;
    state_t      state_nx;
    logic [1:0]  cur;
    logic [1:0]  last_grant;
    logic [1:0]  win;
    logic        we_q;
    logic [11:0] addr_q;
    logic [31:0] data_q;
    logic [2:0]  cnt;
    logic [31:0] rdata1_q;
    logic [31:0] rdata2_q;
    logic        g_we;
    logic [11:0] g_addr;
    logic [31:0] g_data;
    logic        rden;
    logic        wren;
    logic        ack1;
    logic        ack2;

    // On a tie the port that was not served last goes first
    always_comb begin
        win = 2'd0;
        if (bus.req1 && bus.req2)
            win = (last_grant == 2'd1) ? 2'd2 : 2'd1;
        else if (bus.req1)
            win = 2'd1;
        else if (bus.req2)
            win = 2'd2;
    end

    assign g_we   = (win == 2'd2) ? bus.we2    : bus.we1;
    assign g_addr = (win == 2'd2) ? bus.addr2  : bus.addr1;
    assign g_data = (win == 2'd2) ? bus.wdata2 : bus.wdata1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cur        <= 2'd0;
            last_grant <= 2'd2;
            we_q       <= 1'b0;
            addr_q     <= 12'd0;
            data_q     <= 32'd0;
            cnt        <= 3'd0;
            rdata1_q   <= 32'd0;
            rdata2_q   <= 32'd0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (win != 2'd0) begin
                        cur        <= win;
                        last_grant <= win;
                        we_q       <= g_we;
                        addr_q     <= g_addr;
                        if (g_we)
                            data_q <= g_data;
                    end
                end
                ISSUE: cnt <= 3'(MEM_LAT);
                WAIT: begin
                    cnt <= cnt - 3'd1;
                    if (cnt == 3'd1 && !we_q) begin
                        if (cur == 2'd1)
                            rdata1_q <= bus.mem_q;
                        else
                            rdata2_q <= bus.mem_q;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nx = state;
        rden     = 1'b0;
        wren     = 1'b0;
        ack1     = 1'b0;
        ack2     = 1'b0;
        unique case (state)
            IDLE: begin
                if (win != 2'd0)
                    state_nx = ISSUE;
            end
            ISSUE: begin
                state_nx = WAIT;
                rden     = !we_q;
                wren     = we_q;
            end
            WAIT: begin
                if (cnt == 3'd1)
                    state_nx = DONE;
            end
            DONE: begin
                state_nx = IDLE;
                ack1     = (cur == 2'd1);
                ack2     = (cur == 2'd2);
            end
            default: state_nx = IDLE;
        endcase
    end

    // Address/data registers are loaded at grant, so they hold outside ISSUE
    assign bus.mem_addr = addr_q;
    assign bus.mem_data = data_q;
    assign bus.mem_rden = rden;
    assign bus.mem_wren = wren;
    assign bus.ack1     = ack1;
    assign bus.ack2     = ack2;
    assign bus.rdata1   = rdata1_q;
    assign bus.rdata2   = rdata2_q;
    assign bus.busy     = (state != IDLE);

`ifdef MEM_ARB_SNOOP_EN
    logic inv1;
    logic inv2;
    assign inv1           = (state == DONE) && we_q && (cur == 2'd2);
    assign inv2           = (state == DONE) && we_q && (cur == 2'd1);
    assign bus.inv1_valid = inv1;
    assign bus.inv2_valid = inv2;
    assign bus.inv_addr   = (inv1 || inv2) ? addr_q : 12'd0;
`else
    assign bus.inv1_valid = 1'b0;
    assign bus.inv2_valid = 1'b0;
    assign bus.inv_addr   = 12'd0;
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one DUT at MEM_LAT=1, one at MEM_LAT=3.
// Each has a small memory model with the matching read latency.
module tb_mem_arbiter;
`ifdef MEM_ARB_SNOOP_EN
    localparam bit SNOOP = 1'b1;
`else
    localparam bit SNOOP = 1'b0;
`endif

    logic clk;
    logic rst;

    mem_arbiter_if b0();
    mem_arbiter_if b1();

    mem_arbiter #(.MEM_LAT(1)) u0 (.clk(clk), .rst(rst), .bus(b0));
    mem_arbiter #(.MEM_LAT(3)) u1 (.clk(clk), .rst(rst), .bus(b1));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Latency-1 memory with a preload port for the bench
    logic [31:0] mem0 [0:4095];
    logic [31:0] q0;
    logic        pl_we;
    logic [11:0] pl_addr;
    logic [31:0] pl_data;

    always @(posedge clk) begin
        if (pl_we)
            mem0[pl_addr] <= pl_data;
        if (b0.mem_wren)
            mem0[b0.mem_addr] <= b0.mem_data;
        q0 <= b0.mem_rden ? mem0[b0.mem_addr] : 32'd0;
    end
    assign b0.mem_q = q0;

    // Latency-3 memory returning a pattern derived from the address
    logic [31:0] q1p [0:2];
    always @(posedge clk) begin
        q1p[0] <= b1.mem_rden ? {20'hCAFE0, b1.mem_addr} : 32'd0;
        q1p[1] <= q1p[0];
        q1p[2] <= q1p[1];
    end
    assign b1.mem_q = q1p[2];

    int vec;
    int bad;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int n;
    int c;
    int last_c;
    int want;

    initial begin
        vec = 0;
        bad = 0;
        rst = 1'b1;
        pl_we = 1'b0;
        pl_addr = 12'd0;
        pl_data = 32'd0;
        b0.req1 = 0; b0.req2 = 0; b0.we1 = 0; b0.we2 = 0;
        b0.addr1 = 0; b0.addr2 = 0; b0.wdata1 = 0; b0.wdata2 = 0;
        b1.req1 = 0; b1.req2 = 0; b1.we1 = 0; b1.we2 = 0;
        b1.addr1 = 0; b1.addr2 = 0; b1.wdata1 = 0; b1.wdata2 = 0;
        tick();
        pl_we = 1'b1;
        pl_addr = 12'h00A;
        pl_data = 32'hDEADBEEF;
        tick();
        pl_we = 1'b0;

        // Reset state
        chk("rst_busy", b0.busy, 0);
        chk("rst_ack", {b0.ack2, b0.ack1}, 0);
        chk("rst_rdata1", b0.rdata1, 0);
        chk("rst_rdata2", b0.rdata2, 0);
        chk("rst_strobes", {b0.mem_rden, b0.mem_wren}, 0);
        chk("rst_mem_addr", b0.mem_addr, 0);
        chk("rst_mem_data", b0.mem_data, 0);
        chk("rst_inv", {b0.inv1_valid, b0.inv2_valid, b0.inv_addr}, 0);
        rst = 1'b0;

        // Single read from core 1
        b0.req1 = 1; b0.we1 = 0; b0.addr1 = 12'h00A;
        tick();
        chk("rd_issue_rden", b0.mem_rden, 1);
        chk("rd_issue_wren", b0.mem_wren, 0);
        chk("rd_issue_addr", b0.mem_addr, 12'h00A);
        chk("rd_issue_busy", b0.busy, 1);
        chk("rd_issue_ack", {b0.ack2, b0.ack1}, 0);
        tick();
        chk("rd_wait_rden", b0.mem_rden, 0);
        chk("rd_wait_ack", {b0.ack2, b0.ack1}, 0);
        tick();
        chk("rd_done_ack", {b0.ack2, b0.ack1}, 2'b01);
        chk("rd_done_rdata1", b0.rdata1, 32'hDEADBEEF);
        chk("rd_done_inv", {b0.inv1_valid, b0.inv2_valid}, 0);
        b0.req1 = 0;
        tick();
        chk("rd_idle_ack", {b0.ack2, b0.ack1}, 0);
        chk("rd_idle_busy", b0.busy, 0);
        chk("rd_idle_hold", b0.rdata1, 32'hDEADBEEF);

        // Tie after reset: core 1 writes, then core 2 reads it back
        rst = 1'b1;
        tick();
        rst = 1'b0;
        b0.req1 = 1; b0.we1 = 1; b0.addr1 = 12'h123; b0.wdata1 = 32'h55;
        b0.req2 = 1; b0.we2 = 0; b0.addr2 = 12'h123;
        tick();
        chk("tie_wren", b0.mem_wren, 1);
        chk("tie_rden", b0.mem_rden, 0);
        chk("tie_addr", b0.mem_addr, 12'h123);
        chk("tie_data", b0.mem_data, 32'h55);
        b0.addr1 = 12'h777;
        b0.wdata1 = 32'h99;
        b0.we1 = 0;
        tick();
        chk("chg_addr_hold", b0.mem_addr, 12'h123);
        chk("chg_data_hold", b0.mem_data, 32'h55);
        chk("chg_strobes", {b0.mem_rden, b0.mem_wren}, 0);
        tick();
        chk("tie_ack1", {b0.ack2, b0.ack1}, 2'b01);
        chk("tie_inv2", b0.inv2_valid, SNOOP);
        chk("tie_inv1", b0.inv1_valid, 0);
        chk("tie_inv_addr", b0.inv_addr, SNOOP ? 12'h123 : 12'h000);
        b0.req1 = 0;
        tick();
        chk("tie_gap_busy", b0.busy, 0);
        chk("tie_gap_ack", {b0.ack2, b0.ack1}, 0);
        tick();
        chk("tie_p2_rden", b0.mem_rden, 1);
        chk("tie_p2_addr", b0.mem_addr, 12'h123);
        tick();
        tick();
        chk("tie_ack2", {b0.ack2, b0.ack1}, 2'b10);
        chk("tie_rdata2", b0.rdata2, 32'h55);
        chk("wr_keeps_rdata1", b0.rdata1, 0);
        chk("rd_no_inv", {b0.inv1_valid, b0.inv2_valid}, 0);
        b0.req2 = 0;
        tick();

        // Fairness with both requests held
        b0.req1 = 1; b0.we1 = 0; b0.addr1 = 12'h00A;
        b0.req2 = 1; b0.we2 = 0; b0.addr2 = 12'h123;
        n = 0;
        c = 0;
        last_c = 0;
        want = 1;
        while (n < 6 && c < 60) begin
            tick();
            c++;
            if (b0.ack1 || b0.ack2) begin
                chk("fair_who", {30'd0, b0.ack2, b0.ack1}, 32'(want));
                if (want == 1)
                    chk("fair_rdata1", b0.rdata1, 32'hDEADBEEF);
                else
                    chk("fair_rdata2", b0.rdata2, 32'h55);
                if (n > 0)
                    chk("fair_gap", 32'(c - last_c), 4);
                last_c = c;
                n++;
                want = 3 - want;
            end
        end
        chk("fair_count", 32'(n), 6);
        b0.req1 = 0;
        b0.req2 = 0;
        tick();

        // Reset during WAIT of a core-2 read
        b0.req2 = 1; b0.we2 = 0; b0.addr2 = 12'h00A;
        tick();
        chk("abort_issue", b0.mem_rden, 1);
        tick();
        chk("abort_wait_busy", b0.busy, 1);
        rst = 1'b1;
        tick();
        chk("abort_busy", b0.busy, 0);
        chk("abort_ack", {b0.ack2, b0.ack1}, 0);
        chk("abort_strobes", {b0.mem_rden, b0.mem_wren}, 0);
        chk("abort_rdata2", b0.rdata2, 0);
        rst = 1'b0;
        b0.req2 = 0;
        tick();
        chk("abort_no_ack", {b0.ack2, b0.ack1}, 0);

        // MEM_LAT=3: core 2 write, then core 1 read
        b1.req2 = 1; b1.we2 = 1; b1.addr2 = 12'h3FF; b1.wdata2 = 32'hA5A5;
        tick();
        chk("l3_wren", b1.mem_wren, 1);
        chk("l3_addr", b1.mem_addr, 12'h3FF);
        chk("l3_data", b1.mem_data, 32'hA5A5);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("l3_wait", {b1.ack2, b1.ack1, b1.mem_wren, b1.busy}, 4'b0001);
        end
        tick();
        chk("l3_ack2", {b1.ack2, b1.ack1}, 2'b10);
        chk("l3_inv1", b1.inv1_valid, SNOOP);
        chk("l3_inv2", b1.inv2_valid, 0);
        chk("l3_inv_addr", b1.inv_addr, SNOOP ? 12'h3FF : 12'h000);
        b1.req2 = 0;
        tick();
        chk("l3_inv_clear", {b1.inv1_valid, b1.inv2_valid}, 0);
        b1.req1 = 1; b1.we1 = 0; b1.addr1 = 12'h0AB;
        tick();
        chk("l3_rden", b1.mem_rden, 1);
        tick();
        tick();
        tick();
        chk("l3_rd_early", {b1.ack1, b1.rdata1}, 33'd0);
        tick();
        chk("l3_rd_ack1", b1.ack1, 1);
        chk("l3_rd_rdata1", b1.rdata1, 32'hCAFE00AB);
        b1.req1 = 0;
        tick();
        chk("l3_rd_idle", b1.busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter between the per-core cache controllers (P1/c1 and P2/c2) and the single-ported `memoria_principal` block. It serialises main-memory reads and writes with round-robin fairness and a req/ack handshake, so the cores never drive the memory bus at the same time. It also optionally broadcasts write-invalidate pulses so each cache can clear its valid bit when the other core writes a line.

## Interface
Parameters:
- `MEM_LAT`, 1: cycles from the `mem_rden` strobe until `mem_q` is valid (range 1–7).

Ports:
- `clk` in 1: system clock (driven by the divided `clk[25]` at top level).
- `rst` in 1: synchronous, active-high reset.
- `req1` / `req2` in 1: core 1/2 request; held high until the matching ack.
- `we1` / `we2` in 1: 1 = write, 0 = read; sampled at grant.
- `addr1` / `addr2` in 12: word address; sampled at grant.
- `wdata1` / `wdata2` in 32: write data; sampled at grant.
- `ack1` / `ack2` out 1: one-cycle completion pulse.
- `rdata1` / `rdata2` out 32: read data; valid while ack is high and held until the next read for that port.
- `mem_addr` out 12: main-memory address.
- `mem_data` out 32: main-memory write data.
- `mem_rden` / `mem_wren` out 1: main-memory strobes.
- `mem_q` in 32: main-memory read data.
- `busy` out 1: high in any state other than IDLE.
- `inv1_valid` / `inv2_valid` out 1: invalidate pulse toward cache 1/2.
- `inv_addr` out 12: address of the line to invalidate.

## Operation
- FSM states: IDLE → ISSUE → WAIT → DONE → IDLE.
- **IDLE**
  - If any req is high, pick a winner, latch its `we`, `addr` and `wdata` into shadow registers, record `cur` (1 or 2), and go to ISSUE.
  - Stay in IDLE otherwise.
- **Winner selection (round-robin)**
  - A single requester wins.
  - If both request, the port other than `last_grant` wins.
  - `last_grant` updates at grant time.
- **ISSUE** (one cycle)
  - `mem_addr` = shadow address.
  - Write: `mem_wren` = 1, `mem_data` = shadow data.
  - Read: `mem_rden` = 1.
  - Load the wait counter with `MEM_LAT`, then go to WAIT.
- **WAIT**
  - Decrement the counter each cycle; strobes are 0.
  - On the cycle the counter reaches 1: for a read, capture `mem_q` into `rdata<cur>`; then go to DONE.
- **DONE** (one cycle)
  - `ack<cur>` = 1.
  - Requests are not sampled in this state.
  - Next state is IDLE.
- Requester behaviour:
  - The requester must deassert req on the cycle after ack.
  - A req still high in IDLE is treated as a new request.
- Changes to addr, we or wdata after grant are ignored; the shadow registers are authoritative.
- A write leaves `rdata<cur>` unchanged.
- `mem_addr` and `mem_data` hold their last values outside ISSUE; only the strobes are pulsed.

## Timing
- Req sampled high at edge k (IDLE):
  - ISSUE is cycle k+1.
  - WAIT covers cycles k+2 … k+1+`MEM_LAT`.
  - `ack` is high in cycle k+2+`MEM_LAT`.
  - With `MEM_LAT` = 1, ack comes 3 cycles after the sampling edge.
- Minimum spacing between two grants is `MEM_LAT`+3 cycles. A loser that keeps req high is granted on the IDLE cycle right after DONE.
- Strobes are high for exactly one cycle per transaction. `mem_rden` and `mem_wren` are never high together.
- Reset values: state IDLE, `last_grant` = 2 (so core 1 wins the first tie), `cur` = 0. All outputs are 0: acks, rdata, mem_*, strobes, busy, inv*.
- Reset mid-transaction:
  - Return to IDLE on the same edge.
  - Strobes are 0 from the next cycle; no ack is issued.
  - The aborted request must be re-presented.
- `busy` = 1 in ISSUE, WAIT and DONE.

## Configuration
- `MEM_ARB_SNOOP_EN` defined:
  - In DONE of a write from core 1, `inv2_valid` = 1 for that cycle with `inv_addr` = shadow address.
  - Symmetric for core 2 → `inv1_valid`.
  - Reads never raise inv.
- Macro not defined: `inv1_valid`, `inv2_valid` and `inv_addr` are tied to 0; the ports remain present.

## Test plan
- **Single read**, `MEM_LAT`=1: memory preloaded [0x00A]=0xDEADBEEF; `req1`=1, `we1`=0, `addr1`=0x00A.
  - Expect `mem_rden` high one cycle.
  - Expect `ack1` 3 cycles after sampling, `rdata1`=0xDEADBEEF.
  - Expect `ack2`=0 throughout.
- **Simultaneous requests after reset**: `req1` write 0x123→0x55, `req2` read 0x123.
  - Core 1 is served first.
  - Core 2 is granted on the IDLE after `ack1` and reads 0x55.
- **Fairness**: both reqs held continuously for 6 transactions → acks alternate 1,2,1,2,1,2.
- **Reset mid-operation**: assert `rst` in the WAIT of a read from core 2 → no `ack2`, `busy`=0 next cycle, strobes 0, `rdata2` = 0.
- **`MEM_LAT`=3, with `MEM_ARB_SNOOP_EN` defined**: core 2 writes 0x3FF → `mem_wren` at k+1, `ack2` and `inv1_valid` at k+5, `inv_addr`=0x3FF, `inv2_valid`=0.
- **Input change after grant**: `addr1` changes the cycle after grant → `mem_addr` still equals the originally sampled address.
